// File: rtl/mac_rx_frame_if.sv
// PHY receive inputs and decoded frame outputs of mac_rx_frame.
// The DUT uses the slave modport. The PHY model or testbench uses master.
interface mac_rx_frame_if;
    logic [7:0]  rxd;
    logic        rxdv;
    logic [47:0] src_mac_addr;
    logic        head_vld;
    logic [47:0] det_mac_addr;
    logic [47:0] peer_mac_addr;
    logic [15:0] mac_mode;
    logic [7:0]  dout;
    logic        dout_en;
    logic [15:0] data_len;
    logic        fd;
    logic        frame_ok;
    logic        err_crc;
    logic        err_len;

    modport master (
        output rxd, rxdv, src_mac_addr,
        input  head_vld, det_mac_addr, peer_mac_addr, mac_mode,
               dout, dout_en, data_len, fd, frame_ok, err_crc, err_len
    );

    modport slave (
        input  rxd, rxdv, src_mac_addr,
        output head_vld, det_mac_addr, peer_mac_addr, mac_mode,
               dout, dout_en, data_len, fd, frame_ok, err_crc, err_len
    );
endinterface

// File: rtl/mac_rx_frame.sv
// Ethernet receive framer: preamble/SFD detection, header capture, address filter,
// FCS-stripped payload forwarding, CRC-32 and length verdict.
module mac_rx_frame #(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518
) (
    input  logic          clk,
    input  logic          rst,
    mac_rx_frame_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_PREAMBLE, S_HEAD, S_DATA, S_DONE, S_DROP
    } state_t;

    localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
    localparam logic [15:0] MIN_LEN_W   = 16'(MIN_LEN);
    localparam logic [15:0] MAX_LEN_W   = 16'(MAX_LEN);

    state_t        r_state, w_state_next;
    logic [3:0]    r_hcnt;
    logic [103:0]  r_hdr;
    logic [31:0]   r_crc;
    logic [15:0]   r_len;
    logic [31:0]   r_sr;
    logic [2:0]    r_fill;

    logic          r_head_vld, r_dout_en, r_fd, r_frame_ok, r_err_crc, r_err_len;
    logic [47:0]   r_det, r_peer;
    logic [15:0]   r_mode, r_data_len;
    logic [7:0]    r_dout;

    logic [111:0]  w_hdr;
    logic          w_dest_ok, w_sfd, w_accept, w_abort, w_end, w_crc_en;
    logic          w_err_crc, w_err_len;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] x;
        x = c;
        for (int i = 0; i < 8; i++)
            x = (x[0] ^ b[i]) ? ((x >> 1) ^ CRC_POLY) : (x >> 1);
        return x;
    endfunction

    assign w_hdr     = {r_hdr, bus.rxd};
    assign w_dest_ok = (w_hdr[111:64] == bus.src_mac_addr) || (w_hdr[111:64] == 48'hFFFF_FFFF_FFFF);
    // A frame too short to fill the FCS window can never carry a valid CRC.
    assign w_err_crc = (r_crc != CRC_RESIDUE) || (r_fill != 3'd4);
    assign w_err_len = (r_len < MIN_LEN_W);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_sfd        = 1'b0;
        w_accept     = 1'b0;
        w_abort      = 1'b0;
        w_end        = 1'b0;
        w_crc_en     = 1'b0;
        case (r_state)
            // DONE behaves like IDLE so a single-cycle inter-frame gap is enough.
            S_IDLE, S_DONE: begin
                if (bus.rxdv) w_state_next = (bus.rxd == 8'h55) ? S_PREAMBLE : S_DROP;
                else          w_state_next = S_IDLE;
            end
            S_PREAMBLE: begin
                if (!bus.rxdv)              w_state_next = S_IDLE;
                else if (bus.rxd == 8'hD5) begin
                    w_state_next = S_HEAD;
                    w_sfd        = 1'b1;
                end
                else if (bus.rxd != 8'h55)  w_state_next = S_DROP;
            end
            S_HEAD: begin
                if (!bus.rxdv) w_state_next = S_IDLE;
                else begin
                    w_crc_en = 1'b1;
                    if (r_hcnt == 4'd13) begin
                        w_accept     = w_dest_ok;
                        w_state_next = w_dest_ok ? S_DATA : S_DROP;
                    end
                end
            end
            S_DATA: begin
                if (!bus.rxdv) begin
                    w_end        = 1'b1;
                    w_state_next = S_DONE;
                end
                else if (r_len == MAX_LEN_W) begin
                    w_abort      = 1'b1;
                    w_state_next = S_DROP;
                end
                else w_crc_en = 1'b1;
            end
            S_DROP:  if (!bus.rxdv) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hcnt     <= '0;
            r_hdr      <= '0;
            r_crc      <= 32'hFFFF_FFFF;
            r_len      <= '0;
            r_sr       <= '0;
            r_fill     <= '0;
            r_head_vld <= 1'b0;
            r_dout_en  <= 1'b0;
            r_fd       <= 1'b0;
            r_frame_ok <= 1'b0;
            r_err_crc  <= 1'b0;
            r_err_len  <= 1'b0;
            r_det      <= '0;
            r_peer     <= '0;
            r_mode     <= '0;
            r_data_len <= '0;
            r_dout     <= '0;
        end
        else begin
            r_head_vld <= w_accept;
            r_dout_en  <= 1'b0;
            r_fd       <= w_end | w_abort;

            if (w_sfd) begin
                r_crc  <= 32'hFFFF_FFFF;
                r_len  <= '0;
                r_hcnt <= '0;
            end
            if (w_crc_en) r_crc <= crc_byte(r_crc, bus.rxd);
            if (bus.rxdv && (r_state == S_HEAD || r_state == S_DATA) && r_len != 16'hFFFF)
                r_len <= r_len + 16'd1;

            if (r_state == S_HEAD && bus.rxdv) begin
                r_hdr  <= w_hdr[103:0];
                r_hcnt <= r_hcnt + 4'd1;
            end
            if (w_accept) begin
                r_det      <= w_hdr[111:64];
                r_peer     <= w_hdr[63:16];
                r_mode     <= w_hdr[15:0];
                r_data_len <= '0;
                r_fill     <= '0;
            end

            // Four-byte delay line holds back the FCS; only bytes pushed out the far end are payload.
            if (r_state == S_DATA && bus.rxdv && !w_abort) begin
                r_sr <= {r_sr[23:0], bus.rxd};
                if (r_fill == 3'd4) begin
                    r_dout     <= r_sr[31:24];
                    r_dout_en  <= 1'b1;
                    r_data_len <= r_data_len + 16'd1;
                end
                else r_fill <= r_fill + 3'd1;
            end

            if (w_end) begin
                r_err_crc  <= w_err_crc;
                r_err_len  <= w_err_len;
                r_frame_ok <= !w_err_crc && !w_err_len;
            end
            if (w_abort) begin
                r_err_crc  <= 1'b0;
                r_err_len  <= 1'b1;
                r_frame_ok <= 1'b0;
            end
        end
    end

    assign bus.head_vld      = r_head_vld;
    assign bus.det_mac_addr  = r_det;
    assign bus.peer_mac_addr = r_peer;
    assign bus.mac_mode      = r_mode;
    assign bus.dout          = r_dout;
    assign bus.dout_en       = r_dout_en;
    assign bus.data_len      = r_data_len;
    assign bus.fd            = r_fd;
    assign bus.frame_ok      = r_frame_ok;
    assign bus.err_crc       = r_err_crc;
    assign bus.err_len       = r_err_len;
endmodule

// File: tb/tb_mac_rx_frame.sv
// Directed frame sequence with a payload scoreboard and per-frame verdict checks.
module tb_mac_rx_frame;
    logic clk = 1'b0;
    logic rst = 1'b0;

    mac_rx_frame_if bus ();

    mac_rx_frame #(.MIN_LEN(64), .MAX_LEN(1518)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    localparam logic [47:0] LOCAL_MAC = 48'h02_11_22_33_44_55;
    localparam logic [47:0] PEER_MAC  = 48'h00_AA_BB_CC_DD_EE;
    localparam logic [47:0] FOREIGN   = 48'h02_99_88_77_66_55;
    localparam logic [47:0] BCAST     = 48'hFFFF_FFFF_FFFF;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [7:0] sb [$];
    logic [7:0] frame_q [$];
    logic [7:0] mon_exp;

    int n_head, n_dout, n_fd, n_ok, n_after_fd, fd_cyc;
    logic fd_ok, fd_crc, fd_len;
    logic [15:0] fd_dlen;
    int mark_idx = -1;
    int mark_cyc = -1;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops the scoreboard on every payload byte and latches the verdict at fd.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.dout_en) begin
                total++;
                assert (sb.size() != 0) else begin
                    bad++;
                    $error("FAIL dout_extra got=%0h exp=none", bus.dout);
                end
                if (sb.size() != 0) begin
                    mon_exp = sb.pop_front();
                    total++;
                    assert (bus.dout === mon_exp) else begin
                        bad++;
                        $error("FAIL dout_byte got=%0h exp=%0h", bus.dout, mon_exp);
                    end
                end
                total++;
                assert (bus.fd === 1'b0) else begin
                    bad++;
                    $error("FAIL dout_en_with_fd got=%0b exp=0", bus.fd);
                end
                n_dout++;
                if (n_fd > 0) n_after_fd++;
            end
            if (bus.head_vld) n_head++;
            if (bus.fd) begin
                n_fd++;
                fd_ok   = bus.frame_ok;
                fd_crc  = bus.err_crc;
                fd_len  = bus.err_len;
                fd_dlen = bus.data_len;
                fd_cyc  = cyc;
                if (bus.frame_ok) n_ok++;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_counts();
        n_head = 0; n_dout = 0; n_fd = 0; n_ok = 0; n_after_fd = 0; fd_cyc = -1;
        fd_ok = 1'bx; fd_crc = 1'bx; fd_len = 1'bx; fd_dlen = 'x;
    endtask

    task automatic drive(input logic [7:0] b, input logic v);
        bus.rxd  = b;
        bus.rxdv = v;
        @(posedge clk);
        #1;
    endtask

    // Builds header+payload+FCS into frame_q; the first push_n payload bytes go to the scoreboard.
    task automatic build(input logic [47:0] dst, input logic [15:0] etype, input int plen,
                         input int flip, input int push_n, input int seed);
        logic [31:0] c;
        logic [7:0]  b;
        frame_q.delete();
        for (int i = 5; i >= 0; i--) frame_q.push_back(dst[i*8 +: 8]);
        for (int i = 5; i >= 0; i--) frame_q.push_back(PEER_MAC[i*8 +: 8]);
        frame_q.push_back(etype[15:8]);
        frame_q.push_back(etype[7:0]);
        for (int i = 0; i < plen; i++) frame_q.push_back(8'(i * 13 + seed));
        c = 32'hFFFF_FFFF;
        foreach (frame_q[i]) begin
            b = frame_q[i];
            for (int k = 0; k < 8; k++)
                c = (c[0] ^ b[k]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        c = ~c;
        for (int i = 0; i < 4; i++) frame_q.push_back(c[i*8 +: 8]);
        if (flip >= 0) frame_q[14 + flip] = frame_q[14 + flip] ^ 8'h04;
        for (int i = 0; i < push_n; i++) sb.push_back(frame_q[14 + i]);
    endtask

    task automatic send_frame(input int gap, input int rst_at);
        for (int i = 0; i < 7; i++) drive(8'h55, 1'b1);
        drive(8'hD5, 1'b1);
        foreach (frame_q[i]) begin
            if (i == rst_at) begin
                bus.rxdv = 1'b0;
                #2 rst = 1'b1;
                #1;
                chk("rst_async_head_vld", bus.head_vld, 0);
                chk("rst_async_dout_en", bus.dout_en, 0);
                chk("rst_async_data_len", bus.data_len, 0);
                chk("rst_async_det_mac", bus.det_mac_addr, 0);
                chk("rst_async_mac_mode", bus.mac_mode, 0);
                chk("rst_async_frame_ok", bus.frame_ok, 0);
                repeat (2) @(posedge clk);
                #1 rst = 1'b0;
                sb.delete();
                return;
            end
            if (i == mark_idx) mark_cyc = cyc;
            drive(frame_q[i], 1'b1);
        end
        for (int i = 0; i < gap; i++) drive(8'h00, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bus.rxd = 8'h00;
        bus.rxdv = 1'b0;
        bus.src_mac_addr = LOCAL_MAC;
        clear_counts();
        #1 rst = 1'b1;
        #1;
        chk("reset_head_vld", bus.head_vld, 0);
        chk("reset_dout_en", bus.dout_en, 0);
        chk("reset_fd", bus.fd, 0);
        chk("reset_frame_ok", bus.frame_ok, 0);
        chk("reset_err_crc", bus.err_crc, 0);
        chk("reset_err_len", bus.err_len, 0);
        chk("reset_data_len", bus.data_len, 0);
        chk("reset_mac_mode", bus.mac_mode, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        drive(8'h00, 1'b0);

        // Good unicast frame
        clear_counts();
        build(LOCAL_MAC, 16'h0800, 46, -1, 46, 1);
        send_frame(3, -1);
        chk("uni_head_cnt", n_head, 1);
        chk("uni_dout_cnt", n_dout, 46);
        chk("uni_fd_cnt", n_fd, 1);
        chk("uni_frame_ok", fd_ok, 1);
        chk("uni_data_len", fd_dlen, 46);
        chk("uni_mac_mode", bus.mac_mode, 16'h0800);
        chk("uni_det_mac", bus.det_mac_addr, LOCAL_MAC);
        chk("uni_peer_mac", bus.peer_mac_addr, PEER_MAC);
        chk("uni_sb_empty", sb.size(), 0);

        // Same frame with one payload bit flipped
        clear_counts();
        build(LOCAL_MAC, 16'h0800, 46, 5, 46, 1);
        send_frame(3, -1);
        chk("flip_dout_cnt", n_dout, 46);
        chk("flip_fd_cnt", n_fd, 1);
        chk("flip_err_crc", fd_crc, 1);
        chk("flip_frame_ok", fd_ok, 0);
        chk("flip_sb_empty", sb.size(), 0);

        // Broadcast ARP
        clear_counts();
        build(BCAST, 16'h0806, 46, -1, 46, 2);
        send_frame(3, -1);
        chk("bc_head_cnt", n_head, 1);
        chk("bc_mac_mode", bus.mac_mode, 16'h0806);
        chk("bc_det_mac", bus.det_mac_addr, BCAST);
        chk("bc_frame_ok", fd_ok, 1);
        chk("bc_sb_empty", sb.size(), 0);

        // Foreign destination: silently dropped, header outputs hold
        clear_counts();
        build(FOREIGN, 16'h0800, 46, -1, 0, 3);
        send_frame(3, -1);
        chk("foreign_head_cnt", n_head, 0);
        chk("foreign_dout_cnt", n_dout, 0);
        chk("foreign_fd_cnt", n_fd, 0);
        chk("foreign_mode_hold", bus.mac_mode, 16'h0806);

        // Runt: 38 bytes total with valid CRC
        clear_counts();
        build(LOCAL_MAC, 16'h0800, 20, -1, 20, 4);
        send_frame(3, -1);
        chk("runt_fd_cnt", n_fd, 1);
        chk("runt_err_len", fd_len, 1);
        chk("runt_err_crc", fd_crc, 0);
        chk("runt_frame_ok", fd_ok, 0);
        chk("runt_data_len", fd_dlen, 20);
        chk("runt_sb_empty", sb.size(), 0);

        // Oversize: 1600 bytes; aborts on byte 1519 after 1500 payload bytes out
        clear_counts();
        build(LOCAL_MAC, 16'h0800, 1582, -1, 1500, 5);
        mark_idx = 1518;
        send_frame(3, -1);
        mark_idx = -1;
        chk("over_fd_cnt", n_fd, 1);
        chk("over_err_len", fd_len, 1);
        chk("over_frame_ok", fd_ok, 0);
        chk("over_fd_timing", fd_cyc, mark_cyc + 1);
        chk("over_dout_cnt", n_dout, 1500);
        chk("over_dout_after_fd", n_after_fd, 0);
        chk("over_sb_empty", sb.size(), 0);

        // Corrupt preamble, then header truncated at byte 9, then a good frame
        clear_counts();
        drive(8'h55, 1'b1); drive(8'h55, 1'b1); drive(8'hA5, 1'b1);
        drive(8'hD5, 1'b1);
        for (int i = 5; i >= 0; i--) drive(LOCAL_MAC[i*8 +: 8], 1'b1);
        drive(8'h00, 1'b0); drive(8'h00, 1'b0);
        build(LOCAL_MAC, 16'h0800, 46, -1, 0, 6);
        for (int i = 0; i < 7; i++) drive(8'h55, 1'b1);
        drive(8'hD5, 1'b1);
        for (int i = 0; i < 9; i++) drive(frame_q[i], 1'b1);
        drive(8'h00, 1'b0); drive(8'h00, 1'b0);
        chk("junk_head_cnt", n_head, 0);
        chk("junk_fd_cnt", n_fd, 0);
        chk("junk_dout_cnt", n_dout, 0);
        build(LOCAL_MAC, 16'h0800, 50, -1, 50, 7);
        send_frame(3, -1);
        chk("recover_head_cnt", n_head, 1);
        chk("recover_frame_ok", fd_ok, 1);
        chk("recover_data_len", fd_dlen, 50);

        // Reset at payload byte 10, then back-to-back frames with a one-cycle gap
        clear_counts();
        build(LOCAL_MAC, 16'h0800, 46, -1, 46, 8);
        send_frame(3, 24);
        chk("rst_fd_cnt", n_fd, 0);
        drive(8'h00, 1'b0);
        clear_counts();
        build(LOCAL_MAC, 16'h0800, 46, -1, 46, 9);
        send_frame(1, -1);
        build(BCAST, 16'h0806, 48, -1, 48, 10);
        send_frame(3, -1);
        chk("b2b_head_cnt", n_head, 2);
        chk("b2b_fd_cnt", n_fd, 2);
        chk("b2b_ok_cnt", n_ok, 2);
        chk("b2b_dout_cnt", n_dout, 94);
        chk("b2b_last_len", fd_dlen, 48);
        chk("b2b_sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mac_rx_frame.md
Name: mac_rx_frame

Overview:
- Receive-side counterpart of the MAC transmit chain: accepts the raw byte stream from the PHY receive interface.
- Detects preamble/SFD, captures the 14-byte MAC header, filters on destination address and forwards the payload with the FCS stripped.
- Checks CRC-32 and frame length, and reports a per-frame verdict with an fs/fd-style pulse pair.
- Sits between the PHY RX pins and the future ip/arp receive dispatchers, which key off mac_mode.

Parameters:
- MIN_LEN, 64: minimum legal frame length in bytes, destination MAC through FCS.
- MAX_LEN, 1518: maximum legal frame length in bytes, destination MAC through FCS.

Ports:
- clk  in  1  system clock, one RX byte per cycle when rxdv=1.
- rst  in  1  reset, asynchronous, active-high.
- rxd  in  8  PHY receive byte.
- rxdv  in  1  PHY receive data valid.
- src_mac_addr  in  48  local MAC address, used for the destination filter.
- head_vld  out  1  one-cycle pulse: header captured and destination accepted.
- det_mac_addr  out  48  destination MAC of the current frame.
- peer_mac_addr  out  48  source MAC of the current frame.
- mac_mode  out  16  EtherType of the current frame, e.g. 16'h0800 or 16'h0806.
- dout  out  8  payload byte.
- dout_en  out  1  dout valid.
- data_len  out  16  payload bytes emitted so far; final value valid at fd.
- fd  out  1  one-cycle end-of-frame pulse.
- frame_ok  out  1  verdict, valid with fd: CRC good, length legal, not aborted.
- err_crc  out  1  valid with fd.
- err_len  out  1  valid with fd.

Behaviour:
- Reset values: all outputs 0; state IDLE; CRC register 32'hFFFFFFFF; counters 0.
- Reset mid-frame returns to IDLE immediately. No fd is issued for that frame.

State machine (IDLE, PREAMBLE, HEAD, DATA, DONE, DROP):
- IDLE:
  - rxdv=1 and rxd=8'h55 -> PREAMBLE.
  - rxdv=1 with any other byte -> DROP.
- PREAMBLE:
  - rxd=8'h55 -> stay.
  - rxd=8'hD5 -> HEAD; CRC register and length counter are reset.
  - Any other byte -> DROP.
  - rxdv=0 -> IDLE.
- HEAD:
  - Captures 14 bytes MSB-first (6 destination, 6 source, 2 EtherType) into det_mac_addr, peer_mac_addr and mac_mode.
  - After byte 14, destination is accepted if it equals src_mac_addr or 48'hFFFFFFFFFFFF.
  - Accept: head_vld=1 on the following cycle, then -> DATA.
  - Reject: -> DROP; no head_vld and no fd.
  - rxdv=0 in HEAD -> IDLE silently.
- DATA:
  - Each byte enters a 4-deep shift register.
  - When a byte arrives and the register already holds 4 bytes, the oldest byte is registered onto dout with dout_en=1 at the next edge, and data_len increments.
  - The final 4 bytes (FCS) are therefore never emitted.
  - rxdv=0 -> DONE.
- DONE (1 cycle):
  - fd=1.
  - err_crc = (CRC register != 32'hDEBB20E3).
  - err_len = (length < MIN_LEN).
  - frame_ok = !err_crc & !err_len.
  - Then -> IDLE.
  - Frames shorter than 4 payload+FCS bytes: err_crc=1, err_len=1.
- Length overflow in DATA:
  - When the length counter would exceed MAX_LEN: abort, fd=1 next cycle with err_len=1, frame_ok=0, dout_en forced 0.
  - Then -> DROP.
- DROP: ignore input until rxdv=0, then -> IDLE. No outputs are asserted.

CRC:
- Reflected CRC-32, polynomial 32'hEDB88320, LSB-first per byte, init all-ones, no final XOR.
- Updated on every byte from the first destination byte through the last FCS byte.

Length counter:
- 16-bit, counts bytes after SFD.
- Saturates at 16'hFFFF; cannot wrap in practice because MAX_LEN aborts first.

Output timing and holding:
- det_mac_addr, peer_mac_addr and mac_mode hold until the next accepted header.
- fd/err/frame_ok, data_len: err/frame_ok hold until the next fd; data_len is cleared on head_vld.
- dout_en is never 1 in the same cycle as fd.

Downstream contract and back-to-back frames:
- Downstream must discard buffered payload when frame_ok=0.
- Back-to-back frames need at least 1 rxdv=0 cycle between them; the DONE cycle absorbs it.

Test Plan:
1. Good unicast frame: 7x55, D5, destination = src_mac_addr, EtherType 0800, 46-byte payload, correct FCS -> head_vld once; 46 dout_en pulses with matching bytes; fd with frame_ok=1, data_len=46, mac_mode=16'h0800.
2. Same frame with one payload bit flipped -> all 46 bytes still emitted; fd with err_crc=1, frame_ok=0.
3. Broadcast ARP frame (destination FFFFFFFFFFFF, 0806) -> accepted, mac_mode=16'h0806. Frame to a foreign MAC -> no head_vld, no dout_en, no fd.
4. Runt frame (20-byte payload, valid CRC, total 38 bytes) -> fd with err_len=1, frame_ok=0, data_len=20. Oversize frame (1600 bytes) -> fd with err_len=1 right after byte 1519; no dout_en afterwards.
5. Corrupt preamble (55 55 A5) and a header truncated at byte 9 -> no outputs asserted; the next good frame is received normally.
6. rst asserted at payload byte 10 -> all outputs 0 asynchronously, no fd; a back-to-back good frame after release with a single idle cycle gap -> frame_ok=1.
